// File: rtl/reg_file_pkg.sv
// Shared types and default sizing for the clocked register file.
package reg_file_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_t;

   localparam int unsigned DEF_WIDTH = 32;
   localparam int unsigned DEF_DEPTH = 32;
   localparam int unsigned DEF_NRD   = 2;

endpackage

// File: rtl/reg_file.sv
// Multi-read, single-write register file with registered reads, write bypass,
// optional hard-wired zero register and a post-reset clear sequencer.
module reg_file
   import reg_file_pkg::*;
#(
   parameter int unsigned WIDTH    = DEF_WIDTH,
   parameter int unsigned DEPTH    = DEF_DEPTH,
   parameter int unsigned NRD      = DEF_NRD,
   parameter int unsigned ZERO_REG = 1
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    CLR,
   input  logic [NRD*$clog2(DEPTH)-1:0] AR,
   input  logic [$clog2(DEPTH)-1:0] AW,
   input  logic                    REG_WRITE,
   input  logic [WIDTH-1:0]        DIN,
   output logic [NRD*WIDTH-1:0]    DR,
   output logic                    BUSY
);

   localparam int unsigned AWID = $clog2(DEPTH);

   state_t            state;
   logic [AWID-1:0]   cnt;
   logic              busy_q;
   logic [WIDTH-1:0]  mem [0:DEPTH-1];
   logic [WIDTH-1:0]  dr_q [NRD];

   logic              write_ok;
   logic              zero_aw;

   assign zero_aw  = (ZERO_REG != 0) && (AW == '0);
   assign write_ok = (state == READY) && REG_WRITE && !zero_aw;

   // Clear sequencer: walks cnt over every entry, then hands over to READY.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state  <= CLEAR;
         cnt    <= '0;
         busy_q <= 1'b1;
      end else begin
         case (state)
            CLEAR: begin
               if (cnt == AWID'(DEPTH - 1)) begin
                  state  <= READY;
                  cnt    <= '0;
                  busy_q <= 1'b0;
               end else begin
                  cnt <= cnt + AWID'(1);
               end
            end
            READY: begin
               if (CLR) begin
                  state  <= CLEAR;
                  busy_q <= 1'b1;
               end
            end
            default: begin
               state  <= CLEAR;
               cnt    <= '0;
               busy_q <= 1'b1;
            end
         endcase
      end
   end

   // Storage has no reset; the sequencer zeroes it instead.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         if (state == CLEAR) begin
            mem[cnt] <= '0;
         end else if (write_ok) begin
            mem[AW] <= DIN;
         end
      end
   end

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AWID-1:0] ar_k;
      assign ar_k = AR[k*AWID +: AWID];

      always_ff @(posedge CLK) begin
         if (RST || (state == CLEAR)) begin
            dr_q[k] <= '0;
         end else if ((ZERO_REG != 0) && (ar_k == '0)) begin
            dr_q[k] <= '0;
         end else if (REG_WRITE && (AW == ar_k)) begin
            dr_q[k] <= DIN;
         end else begin
            dr_q[k] <= mem[ar_k];
         end
      end

      assign DR[k*WIDTH +: WIDTH] = dr_q[k];
   end

   assign BUSY = busy_q;

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file with default sizing (32 x 32, two read ports).
module tb_reg_file;

   logic        CLK = 1'b0;
   logic        RST;
   logic        CLR;
   logic [9:0]  AR;
   logic [4:0]  AW;
   logic        REG_WRITE;
   logic [31:0] DIN;
   logic [63:0] DR;
   logic        BUSY;

   int tests = 0;
   int fails = 0;
   int n;

   reg_file dut (
      .CLK(CLK), .RST(RST), .CLR(CLR), .AR(AR), .AW(AW),
      .REG_WRITE(REG_WRITE), .DIN(DIN), .DR(DR), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic count_busy(output int cnt_o);
      cnt_o = 0;
      while (BUSY && cnt_o < 100) begin
         tick();
         cnt_o++;
      end
   endtask

   initial begin
      RST = 1'b1; CLR = 1'b0; AR = '0; AW = '0; REG_WRITE = 1'b0; DIN = '0;
      tick();
      tick();
      check("reset_dr", DR[31:0], 32'h0);
      check("reset_dr1", DR[63:32], 32'h0);
      check("reset_busy", {31'b0, BUSY}, 32'h1);

      // Release reset while attempting a write to reg 3.
      RST = 1'b0; REG_WRITE = 1'b1; AW = 5'd3; DIN = 32'hAAAA_AAAA;
      count_busy(n);
      REG_WRITE = 1'b0;
      check("busy_after_reset", n, 32);
      check("busy_low", {31'b0, BUSY}, 32'h0);

      // Every entry reads zero, including reg 3.
      for (int a = 0; a < 32; a++) begin
         AR = {5'(31 - a), 5'(a)};
         tick();
         check($sformatf("clear_rd0_%0d", a), DR[31:0], 32'h0);
         check($sformatf("clear_rd1_%0d", a), DR[63:32], 32'h0);
      end

      // Write then read through memory.
      REG_WRITE = 1'b1; AW = 5'd5; DIN = 32'hDEAD_BEEF; AR = {5'd6, 5'd1};
      tick();
      check("wr_other_port", DR[63:32], 32'h0);
      REG_WRITE = 1'b0; AR = {5'd0, 5'd5};
      tick();
      check("rd_reg5", DR[31:0], 32'hDEAD_BEEF);
      check("rd_zero_port1", DR[63:32], 32'h0);

      // Bypass on both ports to the same address.
      REG_WRITE = 1'b1; AW = 5'd7; DIN = 32'h0000_1234; AR = {5'd7, 5'd7};
      tick();
      check("bypass_p0", DR[31:0], 32'h0000_1234);
      check("bypass_p1", DR[63:32], 32'h0000_1234);
      REG_WRITE = 1'b0; AR = {5'd5, 5'd7};
      tick();
      check("mem_reg7", DR[31:0], 32'h0000_1234);
      check("mem_reg5_p1", DR[63:32], 32'hDEAD_BEEF);

      // Bypass on one port only; the other port reads stored data.
      REG_WRITE = 1'b1; AW = 5'd5; DIN = 32'h5555_0001; AR = {5'd7, 5'd5};
      tick();
      check("bypass_one_p0", DR[31:0], 32'h5555_0001);
      check("bypass_one_p1", DR[63:32], 32'h0000_1234);

      // Zero register ignores writes, also on the bypass path.
      REG_WRITE = 1'b1; AW = 5'd0; DIN = 32'hFFFF_FFFF; AR = {5'd0, 5'd0};
      tick();
      check("zero_bypass_p0", DR[31:0], 32'h0);
      check("zero_bypass_p1", DR[63:32], 32'h0);
      REG_WRITE = 1'b0;
      tick();
      check("zero_mem", DR[31:0], 32'h0);

      // CLR wipes reg 9; a write in the CLR cycle is overwritten too.
      REG_WRITE = 1'b1; AW = 5'd9; DIN = 32'h5;
      tick();
      REG_WRITE = 1'b0; AR = {5'd0, 5'd9};
      tick();
      check("rd_reg9", DR[31:0], 32'h5);
      CLR = 1'b1; REG_WRITE = 1'b1; AW = 5'd11; DIN = 32'h77;
      tick();
      CLR = 1'b0; REG_WRITE = 1'b0;
      check("clr_busy_rise", {31'b0, BUSY}, 32'h1);
      check("clr_last_read", DR[31:0], 32'h5);
      // Writes during busy are dropped.
      REG_WRITE = 1'b1; AW = 5'd12; DIN = 32'h99;
      count_busy(n);
      REG_WRITE = 1'b0;
      check("busy_after_clr", n, 32);
      check("dr_zero_in_clear", DR[31:0], 32'h0);
      AR = {5'd11, 5'd9};
      tick();
      check("reg9_cleared", DR[31:0], 32'h0);
      check("reg11_cleared", DR[63:32], 32'h0);
      AR = {5'd12, 5'd5};
      tick();
      check("reg5_cleared", DR[31:0], 32'h0);
      check("reg12_dropped", DR[63:32], 32'h0);

      // Reset at cnt = 10 restarts a full clear.
      CLR = 1'b1;
      tick();
      CLR = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      check("busy_mid_clear", {31'b0, BUSY}, 32'h1);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      check("rst_mid_busy", {31'b0, BUSY}, 32'h1);
      check("rst_mid_dr", DR[31:0], 32'h0);
      count_busy(n);
      check("busy_after_mid_rst", n, 32);

      // Ready again: a fresh write/read works.
      REG_WRITE = 1'b1; AW = 5'd31; DIN = 32'hCAFE_F00D; AR = {5'd31, 5'd30};
      tick();
      REG_WRITE = 1'b0; AR = {5'd30, 5'd31};
      check("post_rst_bypass", DR[63:32], 32'hCAFE_F00D);
      tick();
      check("post_rst_mem", DR[31:0], 32'hCAFE_F00D);
      check("post_rst_zero", DR[63:32], 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/reg_file.md
# reg_file

Parametrised, clocked successor to the combinational register bank: a multi-read-port, single-write-port register file with registered reads, write-to-read bypass, optional hard-wired zero register, and a hardware clear sequencer that zeroes every entry after reset or on request. It sits between instruction decode and the ALU in the datapath. It replaces file-preloaded contents with deterministic zeroed state, and replaces the latch-like combinational write with an edge-triggered write.

## Interface
Parameters:
- WIDTH, 32, data bits per register
- DEPTH, 32, number of registers; power of two, ≥ 2
- NRD, 2, number of read ports, 1..4
- ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes

Derived constant: AWID = $clog2(DEPTH).

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RST  in  1  reset, synchronous, active-high
- CLR  in  1  request to re-run the clear sequence; sampled only in READY
- AR  in  NRD*AWID  read addresses; port k occupies bits [k*AWID +: AWID]
- AW  in  AWID  write address
- REG_WRITE  in  1  write enable
- DIN  in  WIDTH  write data
- DR  out  NRD*WIDTH  registered read data; port k occupies bits [k*WIDTH +: WIDTH]
- BUSY  out  1  high while the clear sequence runs

## Operation
- The FSM has two states, CLEAR and READY.
- RST high:
  - state = CLEAR, clear counter = 0, DR = 0, BUSY = 1.
  - Memory contents are not touched on the RST edge itself.
- CLEAR state:
  - Each cycle writes 0 to mem[cnt] and increments cnt.
  - When cnt == DEPTH-1 that entry is written and the state moves to READY; cnt returns to 0.
  - REG_WRITE and CLR are ignored; DR is driven to 0 every cycle.
- READY state:
  - REG_WRITE = 1 writes mem[AW] <= DIN at the edge. With ZERO_REG = 1 and AW = 0 the write is dropped.
  - Every read port k updates each edge:
    - DR_k <= 0 if ZERO_REG and AR_k == 0;
    - otherwise DIN if REG_WRITE and AW == AR_k (bypass: new data is visible in the same cycle it is written);
    - otherwise mem[AR_k].
  - CLR = 1 moves the state to CLEAR next cycle. A REG_WRITE in that same cycle still commits, but the clear later overwrites it.
- Several read ports may share an address; each port resolves the bypass independently.
- RST during CLEAR restarts the sequence from cnt = 0.

## Timing
- Read latency: 1 cycle. An address presented in cycle n appears on DR in cycle n+1.
- Write latency: 1 cycle. Data is readable from mem by an address presented in cycle n+1; the same-cycle path is the bypass.
- After RST deasserts, BUSY stays high for exactly DEPTH cycles, then falls. The first write that takes effect is in the cycle BUSY is low.
- A CLR accepted in READY raises BUSY the next cycle, again for DEPTH cycles.
- Reset values: DR = 0, BUSY = 1.
- No combinational path from any input to any output.

## Structure
- Package reg_file_pkg holds:
  - the state typedef (CLEAR = 1'b0, READY = 1'b1);
  - default values for WIDTH, DEPTH and NRD.
- Single module with no sub-module. The per-port read/bypass mux is a generate loop over NRD.
- Memory is a flat array mem[0:DEPTH-1] of WIDTH bits; no reset fan-out into the array.

## Test plan
- Reset then clear: RST high for 2 cycles, then low → BUSY high for 32 cycles, then 0; read all 32 addresses → every DR = 0.
- Write/read: write 32'hDEAD_BEEF to reg 5; next cycle AR0 = 5 → DR0 = 32'hDEAD_BEEF one cycle later.
- Bypass: REG_WRITE = 1, AW = 7, DIN = 32'h1234, AR0 = AR1 = 7 in the same cycle → both DR0 and DR1 = 32'h1234 next cycle.
- Zero register: write 32'hFFFF_FFFF to reg 0, AR0 = 0 (including the bypass case) → DR0 = 0.
- Writes ignored while busy: REG_WRITE = 1 to reg 3 during BUSY → after BUSY falls, reg 3 reads 0.
- CLR and mid-sequence reset:
  - Write reg 9 = 5, then assert CLR → BUSY for 32 cycles; reg 9 reads 0 afterwards.
  - Assert RST when cnt = 10 → a full 32-cycle BUSY period restarts.
